// File: rtl/noc_vc_credit_alloc_if.sv
`default_nettype none
// ============================================================================
//  Module   : noc_vc_credit_alloc_if
//  Purpose  : Bundles the request, credit and allocation signals of the
//             output-port allocator.
//  Ports    : targ     - packed per-input target codes (0 = idle)
//             cred     - per credit-tracked output downstream pop strobes
//             alloc    - per-output allocation flags
//             gnt      - per-output one-hot granted input
//             in_gnt   - per-input "won its output" flags
//             count    - per credit-tracked output occupancy
//             cred_err - sticky credit-underflow flag
//  Modports : master (request/credit source), slave (allocator)
//  Revision : 1.0 - initial release
// ============================================================================
interface noc_vc_credit_alloc_if #(
   parameter int NUM_IN       = 5,
   parameter int NUM_OUT      = 5,
   parameter int NUM_CRED_OUT = 4,
   parameter int TARG_W       = 3,
   parameter int CNT_W        = 3
);
   logic [NUM_IN*TARG_W-1:0]      targ;
   logic [NUM_CRED_OUT-1:0]       cred;
   logic [NUM_OUT-1:0]            alloc;
   logic [NUM_OUT*NUM_IN-1:0]     gnt;
   logic [NUM_IN-1:0]             in_gnt;
   logic [NUM_CRED_OUT*CNT_W-1:0] count;
   logic                          cred_err;

   modport master (
      output targ, cred,
      input  alloc, gnt, in_gnt, count, cred_err
   );

   modport slave (
      input  targ, cred,
      output alloc, gnt, in_gnt, count, cred_err
   );
endinterface
`default_nettype wire

// File: rtl/noc_vc_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : noc_vc_credit_alloc
//  Purpose  : Router output-port allocator. Each output grants at most one
//             requesting input per cycle with a per-output round-robin
//             arbiter; credit-tracked outputs are blocked when the
//             downstream buffer is full.
//  Ports    : clk  - clock
//             rst  - asynchronous active-low reset
//             bus  - noc_vc_credit_alloc_if.slave (targ, cred in;
//                    alloc, gnt, in_gnt, count, cred_err out)
//  Options  : NOC_CREDIT_BYPASS_EN - a full output that receives a credit
//             in the same cycle may still grant (count stays at DEPTH).
//  Revision : 1.0 - initial release
// ============================================================================
module noc_vc_credit_alloc #(
   parameter int NUM_IN       = 5,
   parameter int NUM_OUT      = 5,
   parameter int NUM_CRED_OUT = 4,
   parameter int DEPTH        = 4,
   parameter int TARG_W       = 3,
   parameter int CNT_W        = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   noc_vc_credit_alloc_if.slave     bus
);

   localparam int c_PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   logic [c_PTR_W-1:0]        r_ptr     [NUM_OUT];
   logic [c_PTR_W-1:0]        w_nptr    [NUM_OUT];
   logic [CNT_W-1:0]          r_cnt     [NUM_CRED_OUT];
   logic [CNT_W-1:0]          w_cnt_nxt [NUM_CRED_OUT];
   logic [NUM_OUT-1:0]        w_elig;
   logic [NUM_OUT-1:0]        w_alloc;
   logic [NUM_OUT-1:0]        r_alloc;
   logic [NUM_OUT*NUM_IN-1:0] w_gnt;
   logic [NUM_OUT*NUM_IN-1:0] r_gnt;
   logic [NUM_IN-1:0]         w_in_gnt;
   logic [NUM_IN-1:0]         r_in_gnt;
   logic                      w_err_set;
   logic                      r_err;
   logic [NUM_CRED_OUT*CNT_W-1:0] w_count;

   // Eligibility: tracked outputs need room downstream, local outputs never block.
   for (genvar k = 0; k < NUM_OUT; k++) begin : g_elig
      if (k < NUM_CRED_OUT) begin : g_trk
`ifdef NOC_CREDIT_BYPASS_EN
         // count never exceeds DEPTH, so "full" plus a same-cycle pop is
         // equivalent to count == DEPTH && cred.
         assign w_elig[k] = (r_cnt[k] < CNT_W'(DEPTH)) || bus.cred[k];
`else
         assign w_elig[k] = (r_cnt[k] < CNT_W'(DEPTH));
`endif
      end else begin : g_untrk
         assign w_elig[k] = 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_CRED_OUT; k++) begin : g_cnt
      assign w_count[k*CNT_W +: CNT_W] = r_cnt[k];
   end

   // Round-robin arbitration. Offsets are scanned from farthest to nearest
   // so the requester closest after the pointer is the last one written.
   always_comb begin
      logic [NUM_IN-1:0]  w_req;
      logic [NUM_IN-1:0]  w_sel;
      logic [c_PTR_W-1:0] w_pos;
      w_alloc  = '0;
      w_gnt    = '0;
      w_in_gnt = '0;
      w_req    = '0;
      w_sel    = '0;
      w_pos    = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         w_nptr[k] = r_ptr[k];
         // Codes above NUM_OUT never match any k and so are ignored.
         for (int i = 0; i < NUM_IN; i++) begin
            w_req[i] = (bus.targ[i*TARG_W +: TARG_W] == TARG_W'(k + 1));
         end
         w_sel = '0;
         w_pos = r_ptr[k];
         for (int off = NUM_IN; off >= 1; off--) begin
            for (int i = 0; i < NUM_IN; i++) begin
               if (w_req[i] && (i == ((int'(r_ptr[k]) + off) % NUM_IN))) begin
                  w_sel    = '0;
                  w_sel[i] = 1'b1;
                  w_pos    = c_PTR_W'(i);
               end
            end
         end
         if (w_elig[k] && (w_req != '0)) begin
            w_alloc[k]                 = 1'b1;
            w_gnt[k*NUM_IN +: NUM_IN]  = w_sel;
            w_nptr[k]                  = w_pos;
            w_in_gnt                   = w_in_gnt | w_sel;
         end
      end
   end

   // Occupancy update; a credit on an empty counter is dropped and flagged.
   always_comb begin
      w_err_set = 1'b0;
      for (int k = 0; k < NUM_CRED_OUT; k++) begin
         if (r_cnt[k] == '0) begin
            w_err_set    = w_err_set | bus.cred[k];
            w_cnt_nxt[k] = r_cnt[k] + {{(CNT_W-1){1'b0}}, w_alloc[k]};
         end else begin
            w_cnt_nxt[k] = r_cnt[k] + {{(CNT_W-1){1'b0}}, w_alloc[k]}
                                    - {{(CNT_W-1){1'b0}}, bus.cred[k]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alloc  <= '0;
         r_gnt    <= '0;
         r_in_gnt <= '0;
         r_err    <= 1'b0;
         for (int k = 0; k < NUM_OUT; k++) begin
            r_ptr[k] <= c_PTR_W'(NUM_IN - 1);
         end
         for (int k = 0; k < NUM_CRED_OUT; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         r_alloc  <= w_alloc;
         r_gnt    <= w_gnt;
         r_in_gnt <= w_in_gnt;
         r_err    <= r_err | w_err_set;
         for (int k = 0; k < NUM_OUT; k++) begin
            r_ptr[k] <= w_nptr[k];
         end
         for (int k = 0; k < NUM_CRED_OUT; k++) begin
            r_cnt[k] <= w_cnt_nxt[k];
         end
      end
   end

   assign bus.alloc    = r_alloc;
   assign bus.gnt      = r_gnt;
   assign bus.in_gnt   = r_in_gnt;
   assign bus.count    = w_count;
   assign bus.cred_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_credit_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_vc_credit_alloc
//  Purpose  : Directed self-checking bench for noc_vc_credit_alloc with
//             hand-computed expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noc_vc_credit_alloc;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   noc_vc_credit_alloc_if #(
      .NUM_IN(5), .NUM_OUT(5), .NUM_CRED_OUT(4), .TARG_W(3), .CNT_W(3)
   ) bus ();

   noc_vc_credit_alloc #(
      .NUM_IN(5), .NUM_OUT(5), .NUM_CRED_OUT(4), .DEPTH(4), .TARG_W(3), .CNT_W(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] gsl(input int k);
      return bus.gnt[(k-1)*5 +: 5];
   endfunction

   function automatic logic [2:0] cnt(input int k);
      return bus.count[(k-1)*3 +: 3];
   endfunction

   task automatic set_targ(input int i, input logic [2:0] v);
      bus.targ[i*3 +: 3] = v;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      bus.targ    = '0;
      bus.cred    = '0;

      // Reset state
      tick();
      tick();
      chk("rst_alloc",  32'(bus.alloc),    32'h0);
      chk("rst_gnt",    32'(bus.gnt),      32'h0);
      chk("rst_count",  32'(bus.count),    32'h0);
      chk("rst_err",    32'(bus.cred_err), 32'h0);
      rst = 1'b1;
      tick();
      chk("idle_alloc",  32'(bus.alloc),  32'h0);
      chk("idle_in_gnt", 32'(bus.in_gnt), 32'h0);

      // Round-robin on output 1 among inputs 0,1,2
      set_targ(0, 3'd1); set_targ(1, 3'd1); set_targ(2, 3'd1);
      tick();
      chk("rr_g0",     32'(gsl(1)),     32'h01);
      chk("rr_in0",    32'(bus.in_gnt), 32'h01);
      chk("rr_alloc0", 32'(bus.alloc),  32'h01);
      chk("rr_cnt0",   32'(cnt(1)),     32'h1);
      bus.cred[0] = 1'b1;
      tick();
      chk("rr_g1",   32'(gsl(1)), 32'h02);
      chk("rr_cnt1", 32'(cnt(1)), 32'h1);
      tick();
      chk("rr_g2",   32'(gsl(1)), 32'h04);
      chk("rr_cnt2", 32'(cnt(1)), 32'h1);
      tick();
      chk("rr_g3",   32'(gsl(1)), 32'h01);
      chk("rr_cnt3", 32'(cnt(1)), 32'h1);
      bus.targ = '0;
      tick();
      chk("drain_alloc", 32'(bus.alloc),    32'h0);
      chk("drain_cnt",   32'(cnt(1)),       32'h0);
      chk("drain_err",   32'(bus.cred_err), 32'h0);
      bus.cred = '0;

      // Fill output 2 from input 3
      set_targ(3, 3'd2);
      for (int n = 1; n <= 4; n++) begin
         tick();
         chk("fill_alloc", 32'(bus.alloc[1]), 32'h1);
         chk("fill_gnt",   32'(gsl(2)),       32'h08);
         chk("fill_cnt",   32'(cnt(2)),       32'(n));
      end
      tick();
      chk("full_alloc", 32'(bus.alloc[1]), 32'h0);
      chk("full_in",    32'(bus.in_gnt),   32'h0);
      chk("full_cnt",   32'(cnt(2)),       32'h4);

      // Full boundary with a same-cycle credit
      bus.cred[1] = 1'b1;
      tick();
`ifdef NOC_CREDIT_BYPASS_EN
      chk("bnd_alloc", 32'(bus.alloc[1]), 32'h1);
      chk("bnd_cnt",   32'(cnt(2)),       32'h4);
`else
      chk("bnd_alloc", 32'(bus.alloc[1]), 32'h0);
      chk("bnd_cnt",   32'(cnt(2)),       32'h3);
`endif
      bus.cred = '0;
      tick();
`ifdef NOC_CREDIT_BYPASS_EN
      chk("resume_alloc", 32'(bus.alloc[1]), 32'h0);
`else
      chk("resume_alloc", 32'(bus.alloc[1]), 32'h1);
      chk("resume_in",    32'(bus.in_gnt),   32'h08);
`endif
      chk("resume_cnt", 32'(cnt(2)), 32'h4);

      // Local output 5 never blocked; invalid codes ignored
      bus.targ = '0;
      set_targ(4, 3'd5);
      set_targ(0, 3'd6);
      set_targ(1, 3'd7);
      for (int n = 0; n < 10; n++) begin
         tick();
         chk("local_alloc", 32'(bus.alloc),  32'h10);
         chk("local_in",    32'(bus.in_gnt), 32'h10);
      end
      chk("local_gnt",  32'(gsl(5)), 32'h10);
      chk("local_cnt2", 32'(cnt(2)), 32'h4);

      // Credit underflow on output 1
      bus.targ    = '0;
      bus.cred[0] = 1'b1;
      tick();
      chk("uf_err", 32'(bus.cred_err), 32'h1);
      chk("uf_cnt", 32'(cnt(1)),       32'h0);
      bus.cred = '0;
      tick();
      chk("uf_sticky", 32'(bus.cred_err), 32'h1);

      // Asynchronous reset mid-traffic
      set_targ(4, 3'd5);
      tick();
      chk("pre_rst_alloc", 32'(bus.alloc), 32'h10);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_alloc", 32'(bus.alloc),    32'h0);
      chk("arst_gnt",   32'(bus.gnt),      32'h0);
      chk("arst_in",    32'(bus.in_gnt),   32'h0);
      chk("arst_count", 32'(bus.count),    32'h0);
      chk("arst_err",   32'(bus.cred_err), 32'h0);
      bus.targ = '0;
      tick();
      rst = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
